// File: rtl/key_mmio_pkg.sv
// Shared constants for the push-button scanner: register map and bus width.
package key_mmio_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        KEY_STATE   = 2'd0,
        KEY_PRESS   = 2'd1,
        KEY_RELEASE = 2'd2,
        KEY_IRQEN   = 2'd3
    } key_reg_e;

endpackage

// File: rtl/key_scan_mmio_if.sv
// Register-bus bundle between a CPU-side master and the key scanner.
interface key_scan_mmio_if;
    import key_mmio_pkg::*;

    logic             sel;
    logic             we;
    logic [1:0]       addr;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             irq;

    modport master (output sel, we, addr, wdata, input rdata, irq);
    modport slave  (input sel, we, addr, wdata, output rdata, irq);
endinterface

// File: rtl/key_scan_mmio_debounce.sv
// One push-button channel: 2-flop synchroniser, stability counter, debounced
// level and single-cycle rise/fall pulses coincident with the level toggle.
module key_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             toggle;

    // Any sample that agrees with the current level restarts the count, so a
    // bounce anywhere in the window forces a full fresh qualification period.
    always_comb begin
        sync1_d = key_in;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        toggle  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                toggle  = 1'b1;
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = toggle & ~level_q;
    assign fall  = toggle & level_q;

endmodule

// File: rtl/key_scan_mmio.sv
// Debounced push-button scanner with sticky press/release flags, W1C clears,
// per-key interrupt enables and a registered level interrupt.
module key_scan_mmio
    import key_mmio_pkg::*;
#(
    parameter int NKEYS      = 4,
    parameter int DEB_CYCLES = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] keys_raw,
    key_scan_mmio_if.slave   bus
);

    logic [NKEYS-1:0] key_norm;
    logic [NKEYS-1:0] state_w, rise_w, fall_w;
    logic [NKEYS-1:0] press_q, press_d;
    logic [NKEYS-1:0] release_q, release_d;
    logic [NKEYS-1:0] irq_en_q, irq_en_d;
    logic             irq_q, irq_d;
    logic [NKEYS-1:0] wmask;
    logic             wr_en;
    logic [BUS_W-1:0] rdata_c;
    logic             unused_wdata;

    assign key_norm = (ACTIVE_LOW != 0) ? ~keys_raw : keys_raw;

    for (genvar i = 0; i < NKEYS; i++) begin : g_key
        key_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .key_in (key_norm[i]),
            .level  (state_w[i]),
            .rise   (rise_w[i]),
            .fall   (fall_w[i])
        );
    end

    assign wr_en        = bus.sel & bus.we;
    assign wmask        = bus.wdata[NKEYS-1:0];
    assign unused_wdata = ^bus.wdata;

    // New edges are OR-ed in after the clear so a same-cycle edge survives W1C.
    always_comb begin
        press_d   = press_q | rise_w;
        release_d = release_q | fall_w;
        irq_en_d  = irq_en_q;
        if (wr_en) begin
            case (key_reg_e'(bus.addr))
                KEY_PRESS:   press_d   = (press_q & ~wmask) | rise_w;
                KEY_RELEASE: release_d = (release_q & ~wmask) | fall_w;
                KEY_IRQEN:   irq_en_d  = wmask;
                default:     ;
            endcase
        end
        irq_d = |(press_q & irq_en_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            press_q   <= '0;
            release_q <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata_c = '0;
        if (bus.sel && !bus.we) begin
            case (key_reg_e'(bus.addr))
                KEY_STATE:   rdata_c[NKEYS-1:0] = state_w;
                KEY_PRESS:   rdata_c[NKEYS-1:0] = press_q;
                KEY_RELEASE: rdata_c[NKEYS-1:0] = release_q;
                KEY_IRQEN:   rdata_c[NKEYS-1:0] = irq_en_q;
                default:     rdata_c = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_c;
    assign bus.irq   = irq_q;

endmodule

// File: doc/key_scan_mmio.md
KEY_SCAN_MMIO -- requirements
Module: key_scan_mmio

Interface
REQ-001 SHALL have parameter NKEYS, default 4: number of push-button channels, range 1..32.
REQ-002 SHALL have parameter DEB_CYCLES, default 16: consecutive stable clk cycles that qualify a level change, range 2..65535.
REQ-003 SHALL have parameter ACTIVE_LOW, default 1: 1 means raw key low = pressed.
REQ-004 SHALL have port clk, input, 1 bit: single clock for all state; the only clock.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port keys_raw, input, NKEYS bits: asynchronous button pins.
REQ-007 SHALL have port sel, input, 1 bit: bus access targets this block.
REQ-008 SHALL have port we, input, 1 bit: write strobe, qualified by sel.
REQ-009 SHALL have port addr, input, 2 bits: word offset (byte address bits 3:2).
REQ-010 SHALL have port wdata, input, 32 bits: write data.
REQ-011 SHALL have port rdata, output, 32 bits: read data.
REQ-012 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-013 SHALL normalise polarity per channel (pressed = 1 internally), inverting when ACTIVE_LOW = 1.
REQ-014 SHALL pass each normalised key through a 2-flop synchroniser before any other use.
REQ-015 SHALL keep one debounced level per channel plus a counter of width clog2(DEB_CYCLES).
- sync == level: counter cleared.
- sync != level: counter increments.
- counter == DEB_CYCLES-1 with sync != level: level toggles, counter clears.
REQ-016 SHALL keep the press-to-level latency at exactly 2 + DEB_CYCLES clk cycles for a clean edge; any bounce resets the count.
REQ-017 SHALL set the sticky PRESS bit on a 0->1 level toggle and the sticky RELEASE bit on a 1->0 toggle.
REQ-018 SHALL provide four registers:
- offset 0 STATE: debounced levels, read-only.
- offset 1 PRESS: write-1-to-clear.
- offset 2 RELEASE: write-1-to-clear.
- offset 3 IRQ_EN: read/write, NKEYS bits.
REQ-019 SHALL drive rdata combinationally from addr whenever sel=1 and we=0; bits above NKEYS read 0; rdata = 0 when sel=0.
REQ-020 SHALL take effect on the clk edge where sel=1 and we=1; writes to STATE are ignored.
REQ-021 SHALL let a set win over a clear when a W1C clear and a new edge on the same bit occur in the same cycle (bit remains 1).
REQ-022 SHALL register irq as OR over (PRESS & IRQ_EN), updated one cycle after the causing change.
REQ-023 SHALL handle all channels independently; simultaneous edges on several channels SHALL all be captured.
REQ-024 SHALL produce no edge on debounce-counter wrap: the counter SHALL never exceed DEB_CYCLES-1.

Reset
REQ-025 SHALL, on reset_n low, asynchronously set synchroniser flops, levels, counters, PRESS, RELEASE, IRQ_EN and irq to 0 (released, no pending, disabled).
REQ-026 SHALL abandon any debounce in progress when reset asserts mid-count; a key held through reset release SHALL register as a press after 2 + DEB_CYCLES cycles.

Structure
REQ-027 SHALL place register offset constants (KEY_STATE=0, KEY_PRESS=1, KEY_RELEASE=2, KEY_IRQEN=3) in shared package key_mmio_pkg.
REQ-028 SHALL instantiate one sub-module per channel, key_debounce (sync + counter + level + edge pulses), via generate loop; register file and bus decode SHALL stay in key_scan_mmio.

Verification
REQ-029 SHALL verify: NKEYS=4, DEB_CYCLES=4, keys_raw[1] driven 1->0 cleanly -> STATE=0x2 exactly 6 cycles later, PRESS=0x2.
REQ-030 SHALL verify: keys_raw[0] bouncing (low 3 cycles, high 1, low steady) -> single PRESS bit 0, STATE[0] set 6 cycles after final low.
REQ-031 SHALL verify: IRQ_EN=0x1, press key 0 -> irq=1 next cycle; write PRESS=0x1 -> irq=0 following cycle.
REQ-032 SHALL verify: W1C of PRESS bit 2 in the same cycle as a new key-2 press toggle -> PRESS[2] reads 1.
REQ-033 SHALL verify: reset_n pulsed low mid-debounce with key 3 held -> all registers read 0, then PRESS[3] set 6 cycles after reset release.
REQ-034 SHALL verify: keys 0 and 3 released on the same cycle -> RELEASE=0x9, STATE=0x0; write to STATE ignored.
